ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage OpenMIPS pipeline, sitting directly downstream of the ID stage. It consumes the decoded bundle produced by ID: aluop, alusel, reg1, reg2, wd and wreg. It contains the ID/EX pipeline register, a logic/shift ALU and an iterative 32-cycle multiplier, and registers its result into the EX/MEM register for the MEM stage. While a multiply is in progress it holds the pipeline through `stallreq_o`.

## Interface
Parameters: none. Widths come from the shared defines (`RegBus`=32, `RegAddrBus`=5, `AluOpBus`=8, `AluSelBus`=3).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high (`RstEnable`=1'b1); clears all state immediately.
- `aluop_i`  in  8  operation code from ID.
- `alusel_i`  in  3  result class from ID.
- `reg1_i`, `reg2_i`  in  32  operands from ID.
- `wd_i`  in  5  destination register address.
- `wreg_i`  in  1  destination write enable.
- `stall_i`  in  1  hold the ID/EX register (external pipeline control).
- `flush_i`  in  1  replace the ID/EX contents with a NOP; aborts a multiply.
- `stallreq_o`  out  1  combinational; high while a multiply has not yet completed.
- `wd_o`  out  5  EX/MEM destination address.
- `wreg_o`  out  1  EX/MEM write enable.
- `wdata_o`  out  32  EX/MEM result.

## Operation
- Stage A (ID/EX register) holds aluop, alusel, reg1, reg2, wd and wreg.
  - Reset or flush loads a NOP: `EXE_NOP_OP`=8'h00, `EXE_RES_NOP`=3'b000, wd=0, wreg=0, operands=0.
  - Otherwise Stage A loads the inputs when `stall_i`=0 and `stallreq_o`=0; in all other cases it holds.
- The ALU is combinational from Stage A.
  - Logic ops, with `EXE_RES_LOGIC`=3'b001:
    - OR 8'h25: r1|r2.
    - AND 8'h24: r1&r2.
    - XOR 8'h26: r1^r2.
    - NOR 8'h27: ~(r1|r2).
  - Shift ops, with `EXE_RES_SHIFT`=3'b010: the shift amount is r1[4:0] and the operand is r2.
    - SLL 8'h7C: logical left.
    - SRL 8'h02: logical right.
    - SRA 8'h03: arithmetic right, replicating r2[31].
  - MUL 8'hA9 (`EXE_RES_MUL`=3'b101): unsigned shift-add; the low 32 bits of r1×r2 are written.
  - Any unrecognised aluop or alusel yields a result of 0. wreg passes through unchanged.
- Multiplier FSM, states IDLE, BUSY and DONE:
  - IDLE, Stage A holds MUL: `stallreq_o`=1. On the next edge, load multiplicand=r1, multiplier=r2, acc=0, cnt=0, and go to BUSY.
  - BUSY: `stallreq_o`=1. Each edge:
    - if multiplier[0] is set, acc += multiplicand (mod 2^32);
    - multiplicand <<= 1, multiplier >>= 1, cnt++.
    - When cnt reaches 31, that edge's step completes and the FSM goes to DONE (32 steps total).
  - DONE: `stallreq_o`=0 and the result is acc. On the next edge Stage B captures acc, Stage A advances, and the FSM returns to IDLE.
  - `flush_i` or reset in any state: go to IDLE, Stage A becomes a NOP, and no multiply result is written.
- Stage B (EX/MEM register) captures wd, wreg and the result every edge.
  - When `stallreq_o`=1, Stage B captures a bubble: wreg=0, wd=0, wdata=0.
  - While `stall_i`=1 with no multiply pending, Stage B also captures a bubble, so MEM never sees a duplicate write.

## Timing
- Reset values: `wd_o`=0, `wreg_o`=0, `wdata_o`=0, `stallreq_o`=0, FSM=IDLE, Stage A=NOP.
- Single-cycle ops: the ID bundle captured at edge N appears on `wd_o`/`wreg_o`/`wdata_o` after edge N+1. Latency is 2 edges and throughput is 1 per cycle.
- MUL captured at edge N:
  - `stallreq_o` is high from edge N through the cycle before edge N+33 (33 cycles).
  - The FSM is in DONE in the cycle after edge N+33.
  - The product is on `wdata_o` after edge N+34.
- `flush_i` and `stall_i` together: flush wins.
- Reset asserted mid-multiply: the outputs clear asynchronously, with no partial result.

## Structure
- The shared defines package holds:
  - the opcode constants (`EXE_*_OP`);
  - the result-class constants (`EXE_RES_*`);
  - the FSM state encodings;
  - `RstEnable`, `ZeroWord`, `NOPRegAddr`, `WriteEnable`/`WriteDisable`.
- One sub-module, `mul_iter`, contains the shift-add datapath, the counter and the FSM. Its interface is start/flush/operands in and busy/done/product out.
- `ex_stage` instantiates `mul_iter` and contains Stage A, the ALU mux and Stage B.

## Test plan
- Reset mid-stream: assert `rst` asynchronously between edges -> all outputs read 0 immediately; `stallreq_o`=0.
- Back-to-back single-cycle ops:
  - OR r1=32'h0000_F0F0, r2=32'h0000_0F0F, wd=5 -> `wdata_o`=32'h0000_FFFF, wd=5, wreg=1 two edges later.
  - NOR of 0 and 0 on the next cycle -> 32'hFFFF_FFFF one cycle after.
- Shifts: SRA r1=4, r2=32'h8000_0000 -> 32'hF800_0000; SRL with the same operands -> 32'h0800_0000; SLL r1=31, r2=1 -> 32'h8000_0000.
- MUL r1=32'h0001_0003, r2=32'h0000_0005:
  - `stallreq_o` high for exactly 33 cycles;
  - wreg=0 bubbles during the stall;
  - then `wdata_o`=32'h0005_000F.
  - Following instruction held in Stage A, then executes normally.
- MUL overflow: r1=r2=32'hFFFF_FFFF -> `wdata_o`=32'h0000_0001.
- Flush at BUSY cycle 10 of a MUL -> `stallreq_o` drops next cycle, no write with that wd ever appears, next OR completes normally; `stall_i`=1 on a single-cycle op -> Stage A holds and a bubble is emitted each held cycle.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared widths, opcodes, result classes and state encodings for the OpenMIPS EX stage.
package ex_stage_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 8;
    localparam int AluSelBus  = 3;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam logic [RegBus-1:0]     ZeroWord   = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

    localparam logic [AluOpBus-1:0] EXE_NOP_OP = 8'h00;
    localparam logic [AluOpBus-1:0] EXE_AND_OP = 8'h24;
    localparam logic [AluOpBus-1:0] EXE_OR_OP  = 8'h25;
    localparam logic [AluOpBus-1:0] EXE_XOR_OP = 8'h26;
    localparam logic [AluOpBus-1:0] EXE_NOR_OP = 8'h27;
    localparam logic [AluOpBus-1:0] EXE_SLL_OP = 8'h7C;
    localparam logic [AluOpBus-1:0] EXE_SRL_OP = 8'h02;
    localparam logic [AluOpBus-1:0] EXE_SRA_OP = 8'h03;
    localparam logic [AluOpBus-1:0] EXE_MUL_OP = 8'hA9;

    localparam logic [AluSelBus-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [AluSelBus-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [AluSelBus-1:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [AluSelBus-1:0] EXE_RES_MUL   = 3'b101;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    typedef struct packed {
        logic [AluOpBus-1:0]   aluop;
        logic [AluSelBus-1:0]  alusel;
        logic [RegBus-1:0]     reg1;
        logic [RegBus-1:0]     reg2;
        logic [RegAddrBus-1:0] wd;
        logic                  wreg;
    } idex_t;

    localparam idex_t IDEX_NOP = '{
        aluop:  EXE_NOP_OP,
        alusel: EXE_RES_NOP,
        reg1:   ZeroWord,
        reg2:   ZeroWord,
        wd:     NOPRegAddr,
        wreg:   WriteDisable
    };

    // Arithmetic right shift done as a logical shift of a sign-extended 64-bit word.
    function automatic logic [RegBus-1:0] sra32(input logic [RegBus-1:0] val,
                                                input logic [4:0] sh);
        logic [2*RegBus-1:0] ext;
        ext = {{RegBus{val[RegBus-1]}}, val} >> sh;
        return ext[RegBus-1:0];
    endfunction

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Iterative 32-step shift-add multiplier (low 32 bits of a*b) with IDLE/BUSY/DONE control.
module mul_iter
    import ex_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    input  logic              hold,
    input  logic [RegBus-1:0] a,
    input  logic [RegBus-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [RegBus-1:0] product
);

    mul_state_e        state;
    logic [RegBus-1:0] mcand;
    logic [RegBus-1:0] mplier;
    logic [RegBus-1:0] acc;
    logic [4:0]        cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state  <= MUL_IDLE;
            mcand  <= ZeroWord;
            mplier <= ZeroWord;
            acc    <= ZeroWord;
            cnt    <= 5'd0;
        end else if (flush) begin
            state <= MUL_IDLE;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= ZeroWord;
                        cnt    <= 5'd0;
                        state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= MUL_DONE;
                end
                // Wait out an external stall so the product is handed over exactly once.
                MUL_DONE: begin
                    if (!hold)
                        state <= MUL_IDLE;
                end
                default: state <= MUL_IDLE;
            endcase
        end
    end

    assign busy    = (state == MUL_BUSY) || (state == MUL_IDLE && start);
    assign done    = (state == MUL_DONE);
    assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// OpenMIPS execute stage: ID/EX register, logic/shift ALU, iterative MUL, EX/MEM register.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AluOpBus-1:0]   aluop_i,
    input  logic [AluSelBus-1:0]  alusel_i,
    input  logic [RegBus-1:0]     reg1_i,
    input  logic [RegBus-1:0]     reg2_i,
    input  logic [RegAddrBus-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  stallreq_o,
    output logic [RegAddrBus-1:0] wd_o,
    output logic                  wreg_o,
    output logic [RegBus-1:0]     wdata_o
);

    idex_t             stage_a;
    logic              a_is_mul;
    logic              mul_busy;
    logic              mul_done;
    logic [RegBus-1:0] mul_prod;
    logic [RegBus-1:0] logic_res;
    logic [RegBus-1:0] shift_res;
    logic [RegBus-1:0] alu_res;
    logic              bubble;

    assign a_is_mul = (stage_a.aluop == EXE_MUL_OP) && (stage_a.alusel == EXE_RES_MUL);

    mul_iter u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (a_is_mul),
        .flush   (flush_i),
        .hold    (stall_i),
        .a       (stage_a.reg1),
        .b       (stage_a.reg2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    assign stallreq_o = mul_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            stage_a <= IDEX_NOP;
        end else if (flush_i) begin
            stage_a <= IDEX_NOP;
        end else if (!stall_i && !stallreq_o) begin
            stage_a <= '{
                aluop:  aluop_i,
                alusel: alusel_i,
                reg1:   reg1_i,
                reg2:   reg2_i,
                wd:     wd_i,
                wreg:   wreg_i
            };
        end
    end

    always_comb begin
        logic_res = ZeroWord;
        case (stage_a.aluop)
            EXE_OR_OP:  logic_res = stage_a.reg1 | stage_a.reg2;
            EXE_AND_OP: logic_res = stage_a.reg1 & stage_a.reg2;
            EXE_XOR_OP: logic_res = stage_a.reg1 ^ stage_a.reg2;
            EXE_NOR_OP: logic_res = ~(stage_a.reg1 | stage_a.reg2);
            default:    logic_res = ZeroWord;
        endcase
    end

    always_comb begin
        shift_res = ZeroWord;
        case (stage_a.aluop)
            EXE_SLL_OP: shift_res = stage_a.reg2 << stage_a.reg1[4:0];
            EXE_SRL_OP: shift_res = stage_a.reg2 >> stage_a.reg1[4:0];
            EXE_SRA_OP: shift_res = sra32(stage_a.reg2, stage_a.reg1[4:0]);
            default:    shift_res = ZeroWord;
        endcase
    end

    always_comb begin
        alu_res = ZeroWord;
        case (stage_a.alusel)
            EXE_RES_LOGIC: alu_res = logic_res;
            EXE_RES_SHIFT: alu_res = shift_res;
            EXE_RES_MUL:   alu_res = (stage_a.aluop == EXE_MUL_OP) ? mul_prod : ZeroWord;
            default:       alu_res = ZeroWord;
        endcase
    end

    // A flush landing on a finished multiply discards its product.
    assign bubble = stallreq_o || stall_i || (flush_i && mul_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            wd_o    <= NOPRegAddr;
            wreg_o  <= WriteDisable;
            wdata_o <= ZeroWord;
        end else if (bubble) begin
            wd_o    <= NOPRegAddr;
            wreg_o  <= WriteDisable;
            wdata_o <= ZeroWord;
        end else begin
            wd_o    <= stage_a.wd;
            wreg_o  <= stage_a.wreg;
            wdata_o <= alu_res;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases with literal expectations plus random traffic vs a model.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  aluop_i = 8'h00;
    logic [2:0]  alusel_i = 3'b000;
    logic [31:0] reg1_i = '0;
    logic [31:0] reg2_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        stallreq_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;

    int total = 0;
    int bad = 0;

    ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .stallreq_o (stallreq_o),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        w;
    } ins_t;

    // Model: held instruction, edges elapsed since it was taken, and expected EX/MEM contents.
    ins_t        m_a;
    int          m_k;
    logic [4:0]  m_wd;
    logic        m_wreg;
    logic [31:0] m_data;

    function automatic logic is_mul(input ins_t x);
        return x.op == 8'hA9 && x.sel == 3'b101;
    endfunction

    function automatic logic [31:0] result_of(input ins_t x);
        logic [31:0] r;
        r = 32'h0;
        case (x.sel)
            3'b001: case (x.op)
                8'h25: r = x.r1 | x.r2;
                8'h24: r = x.r1 & x.r2;
                8'h26: r = x.r1 ^ x.r2;
                8'h27: r = ~(x.r1 | x.r2);
                default: r = 32'h0;
            endcase
            3'b010: case (x.op)
                8'h7C: r = x.r2 << x.r1[4:0];
                8'h02: r = x.r2 >> x.r1[4:0];
                8'h03: r = $signed(x.r2) >>> x.r1[4:0];
                default: r = 32'h0;
            endcase
            3'b101: r = (x.op == 8'hA9) ? x.r1 * x.r2 : 32'h0;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic logic model_stallreq();
        return is_mul(m_a) && m_k <= 32;
    endfunction

    initial begin
        ins_t cur;
        logic bub;
        m_a = '0; m_k = 0; m_wd = '0; m_wreg = 1'b0; m_data = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_a = '0; m_k = 0; m_wd = '0; m_wreg = 1'b0; m_data = '0;
            end else begin
                cur = '{op: aluop_i, sel: alusel_i, r1: reg1_i, r2: reg2_i, wd: wd_i, w: wreg_i};
                bub = stall_i || model_stallreq() || (is_mul(m_a) && flush_i);
                if (bub) begin
                    m_wd = '0; m_wreg = 1'b0; m_data = '0;
                end else begin
                    m_wd = m_a.wd; m_wreg = m_a.w; m_data = result_of(m_a);
                end
                if (flush_i) begin
                    m_a = '0; m_k = 0;
                end else if (model_stallreq()) begin
                    m_k = m_k + 1;
                end else if (!stall_i) begin
                    m_a = cur; m_k = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("model_stallreq", 32'(stallreq_o), 32'(model_stallreq()));
            chk("model_wd",       32'(wd_o),       32'(m_wd));
            chk("model_wreg",     32'(wreg_o),     32'(m_wreg));
            chk("model_wdata",    wdata_o,         m_data);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic setin(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [4:0] wd, input logic w);
        aluop_i = op; alusel_i = sel; reg1_i = r1; reg2_i = r2; wd_i = wd; wreg_i = w;
    endtask

    task automatic nop();
        setin(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    // Counts stall cycles from the current negedge until stallreq_o drops, bounded.
    task automatic wait_mul(input string name, output int n);
        n = 0;
        while (stallreq_o && n < 40) begin
            n++;
            cyc();
        end
        if (stallreq_o) chk({name, "_timeout"}, 32'(stallreq_o), 32'h0);
    endtask

    initial begin
        int n;
        int r;
        logic [7:0] ops [9];
        logic [2:0] sels [9];
        ops  = '{8'h25, 8'h24, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03, 8'hA9, 8'h00};
        sels = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b101, 3'b000};

        cyc(); cyc();
        rst = 1'b0;
        chk("reset_wd", 32'(wd_o), 32'h0);
        chk("reset_wreg", 32'(wreg_o), 32'h0);
        chk("reset_wdata", wdata_o, 32'h0);
        chk("reset_stallreq", 32'(stallreq_o), 32'h0);

        setin(8'h25, 3'b001, 32'h0000_F0F0, 32'h0000_0F0F, 5'd5, 1'b1);
        cyc();
        setin(8'h27, 3'b001, 32'h0, 32'h0, 5'd6, 1'b1);
        cyc();
        chk("or_data", wdata_o, 32'h0000_FFFF);
        chk("or_wd", 32'(wd_o), 32'd5);
        chk("or_wreg", 32'(wreg_o), 32'd1);
        nop();
        cyc();
        chk("nor_data", wdata_o, 32'hFFFF_FFFF);

        setin(8'h03, 3'b010, 32'd4, 32'h8000_0000, 5'd1, 1'b1);
        cyc();
        setin(8'h02, 3'b010, 32'd4, 32'h8000_0000, 5'd2, 1'b1);
        cyc();
        chk("sra", wdata_o, 32'hF800_0000);
        setin(8'h7C, 3'b010, 32'd31, 32'd1, 5'd3, 1'b1);
        cyc();
        chk("srl", wdata_o, 32'h0800_0000);
        nop();
        cyc();
        chk("sll", wdata_o, 32'h8000_0000);

        setin(8'hA9, 3'b101, 32'h0001_0003, 32'h0000_0005, 5'd7, 1'b1);
        cyc();
        setin(8'h25, 3'b001, 32'h0000_F0F0, 32'h0000_0F0F, 5'd8, 1'b1);
        wait_mul("mul", n);
        chk("mul_stall_cycles", 32'(n), 32'd33);
        cyc();
        chk("mul_data", wdata_o, 32'h0005_000F);
        chk("mul_wd", 32'(wd_o), 32'd7);
        nop();
        cyc();
        chk("after_mul_data", wdata_o, 32'h0000_FFFF);
        chk("after_mul_wd", 32'(wd_o), 32'd8);

        setin(8'hA9, 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b1);
        cyc();
        nop();
        wait_mul("mul_ovf", n);
        cyc();
        chk("mul_overflow", wdata_o, 32'h0000_0001);

        setin(8'hA9, 3'b101, 32'h1234_5678, 32'h9, 5'd9, 1'b1);
        cyc();
        nop();
        repeat (10) cyc();
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        chk("flush_stallreq", 32'(stallreq_o), 32'h0);
        setin(8'h25, 3'b001, 32'h1, 32'h2, 5'd10, 1'b1);
        cyc();
        nop();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (wreg_o && wd_o == 5'd9) n++;
            if (i == 0) chk("post_flush_or", wdata_o, 32'h3);
        end
        chk("flushed_write_seen", 32'(n), 32'h0);

        setin(8'h24, 3'b001, 32'hF0, 32'h3C, 5'd3, 1'b1);
        cyc();
        stall_i = 1'b1;
        setin(8'h26, 3'b001, 32'hF0, 32'h3C, 5'd4, 1'b1);
        cyc();
        chk("stall_bubble1", 32'(wreg_o), 32'h0);
        cyc();
        chk("stall_bubble2", 32'(wreg_o), 32'h0);
        stall_i = 1'b0;
        cyc();
        chk("stall_release_and", wdata_o, 32'h30);
        chk("stall_release_wd", 32'(wd_o), 32'd3);
        nop();
        cyc();
        chk("stall_next_xor", wdata_o, 32'hCC);

        setin(8'hA9, 3'b101, 32'h7, 32'h7, 5'd12, 1'b1);
        cyc();
        nop();
        repeat (5) cyc();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_wd", 32'(wd_o), 32'h0);
        chk("async_rst_wreg", 32'(wreg_o), 32'h0);
        chk("async_rst_wdata", wdata_o, 32'h0);
        chk("async_rst_stallreq", 32'(stallreq_o), 32'h0);
        #1 rst = 1'b0;

        for (int i = 0; i < 2500; i++) begin
            cyc();
            r = int'($urandom_range(0, 8));
            if (r == 7 && $urandom_range(0, 3) != 0) r = 0;
            setin(ops[r], sels[r], $urandom(), $urandom(), 5'($urandom()), 1'($urandom()));
            if ($urandom_range(0, 9) == 0) alusel_i = 3'($urandom());
            stall_i = ($urandom_range(0, 7) == 0);
            flush_i = ($urandom_range(0, 59) == 0);
        end
        cyc();
        stall_i = 1'b0;
        flush_i = 1'b0;
        nop();
        repeat (40) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
